// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator (640x480@60 by default).
// Produces pixel coordinates, an internal active-high vsync and an
// active-video flag for the game logic. It also has a one-pixel-latency
// output stage that drives blanked RGB and negative-polarity sync pins.
module vga_timing #(
  parameter int CLKDIV   = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vsync,
  output logic       active,
  output logic       pix_en,
  output logic       newframe,
  input  logic [2:0] color_in,
  output logic [2:0] vga_rgb,
  output logic       vga_hs_n,
  output logic       vga_vs_n
);

  // Raster geometry. All position arithmetic is 10-bit unsigned, so the
  // totals must fit in 1024.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The divider needs at least one bit even when CLKDIV is 1.
  localparam int              DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             div_wrap;
  logic             pix_en_reg;

  logic [9:0]       x_reg;
  logic [9:0]       x_next;
  logic [9:0]       y_reg;
  logic [9:0]       y_next;
  logic             newframe_reg;
  logic             newframe_next;
  logic             vsync_reg;
  logic             vsync_next;
  logic             active_reg;
  logic             active_next;

  logic             hsync_cur;
  logic [2:0]       rgb_next;
  logic [2:0]       rgb_reg;
  logic             hs_n_reg;
  logic             vs_n_reg;

  // ------------------------------------------------------------------
  // Pixel clock divider
  // ------------------------------------------------------------------

  // Divider next state: count 0..CLKDIV-1 and flag the last step.
  always_comb begin
    div_wrap = (div_reg == DIV_LAST);
    div_next = div_reg + DIV_W'(1);
    if (div_wrap) begin
      div_next = '0;
    end
  end

  // Divider register; the strobe is registered so it is clean and low in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_reg    <= '0;
      pix_en_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      pix_en_reg <= div_wrap;
    end
  end

  // ------------------------------------------------------------------
  // Raster counters
  // ------------------------------------------------------------------

  // Next position: step x on each pixel strobe, carry into y at the end
  // of a line, and flag the frame wrap back to (0,0).
  always_comb begin
    x_next        = x_reg;
    y_next        = y_reg;
    newframe_next = 1'b0;
    if (pix_en_reg) begin
      if (x_reg == H_LAST) begin
        x_next = 10'd0;
        if (y_reg == V_LAST) begin
          y_next        = 10'd0;
          newframe_next = 1'b1;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  // Vsync and active are decoded from the next position so that, once
  // registered, they describe exactly the pixel held in x_reg/y_reg.
  always_comb begin
    vsync_next  = (y_next >= VS_START) && (y_next <= VS_END);
    active_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Position register plus its aligned decodes; reset parks at (0,0).
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_reg        <= 10'd0;
      y_reg        <= 10'd0;
      newframe_reg <= 1'b0;
      vsync_reg    <= 1'b0;
      active_reg   <= 1'b1;
    end else begin
      x_reg        <= x_next;
      y_reg        <= y_next;
      newframe_reg <= newframe_next;
      vsync_reg    <= vsync_next;
      active_reg   <= active_next;
    end
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------

  // Horizontal sync decode for the pixel currently on x_reg.
  always_comb begin
    hsync_cur = (x_reg >= HS_START) && (x_reg <= HS_END);
  end

  // Blank each colour bit outside the visible area.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_blank
      assign rgb_next[gi] = active_reg & color_in[gi];
    end
  endgenerate

  // Pin registers load once per pixel, so colour and both syncs for the
  // same pixel appear together one pixel period after x/y showed it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_reg  <= 3'b000;
      hs_n_reg <= 1'b1;
      vs_n_reg <= 1'b1;
    end else if (pix_en_reg) begin
      rgb_reg  <= rgb_next;
      hs_n_reg <= ~hsync_cur;
      vs_n_reg <= ~vsync_reg;
    end
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign vsync    = vsync_reg;
  assign active   = active_reg;
  assign pix_en   = pix_en_reg;
  assign newframe = newframe_reg;
  assign vga_rgb  = rgb_reg;
  assign vga_hs_n = hs_n_reg;
  assign vga_vs_n = vs_n_reg;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: two instances -- full 640x480 timing with CLKDIV=2 (a few
// lines only) and a miniature raster with CLKDIV=1 (many whole frames).
// Expected values come from an arithmetic model driven by the number of
// clock edges since reset release; pin values go through a scoreboard queue.
module tb_vga_timing;

  localparam int A_C  = 2;
  localparam int B_C  = 1;
  localparam int B_HA = 8;
  localparam int B_HF = 2;
  localparam int B_HS = 3;
  localparam int B_HB = 2;
  localparam int B_VA = 6;
  localparam int B_VF = 1;
  localparam int B_VS = 2;
  localparam int B_VB = 2;

  typedef struct { int c; int ha; int hf; int hs; int ht; int va; int vf; int vs; int vt; } geo_t;
  typedef struct { logic [2:0] rgb; logic hs_n; logic vs_n; } pins_t;
  typedef struct { int x; int y; int vsync; int active; int pe; int nf; } cnt_t;
  typedef struct { int x; int y; int vsync; int active; int pe; int nf; int rgb; int hs_n; int vs_n; } obs_t;
  typedef struct { logic [2:0] color; int a_x; int a_pe; int a_rgb; int b_x; int b_pe; int b_rgb; } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] color_a = 3'b000;
  logic [2:0] color_b = 3'b000;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       vsync_a, active_a, pix_en_a, newframe_a, vga_hs_n_a, vga_vs_n_a;
  logic       vsync_b, active_b, pix_en_b, newframe_b, vga_hs_n_b, vga_vs_n_b;
  logic [2:0] vga_rgb_a, vga_rgb_b;

  vga_timing #(.CLKDIV(A_C)) dut_a (
    .clk(clk), .rst(rst), .x(x_a), .y(y_a), .vsync(vsync_a), .active(active_a),
    .pix_en(pix_en_a), .newframe(newframe_a), .color_in(color_a),
    .vga_rgb(vga_rgb_a), .vga_hs_n(vga_hs_n_a), .vga_vs_n(vga_vs_n_a)
  );

  vga_timing #(
    .CLKDIV(B_C), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .clk(clk), .rst(rst), .x(x_b), .y(y_b), .vsync(vsync_b), .active(active_b),
    .pix_en(pix_en_b), .newframe(newframe_b), .color_in(color_b),
    .vga_rgb(vga_rgb_b), .vga_hs_n(vga_hs_n_b), .vga_vs_n(vga_vs_n_b)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    n_edge [2];
  pins_t q_a[$];
  pins_t q_b[$];
  pins_t exp_pins [2];
  bit    chk_en = 1'b0;
  vec_t  tbl [8];

  // statistics for the frame-level checks
  int last_nf_b = 0;
  int vs_cnt_b  = 0;
  int hs_cnt_a  = 0;
  int hs_first  = -1;
  bit hs_done   = 1'b0;
  int max_x_a   = 0;
  int max_x_b   = 0;
  int max_y_b   = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic geo_t geom(int i);
    geo_t g;
    if (i == 0) g = '{2, 640, 16, 96, 800, 480, 10, 2, 525};
    else        g = '{1, 8, 2, 3, 15, 6, 1, 2, 11};
    return g;
  endfunction

  // pixel index reached after edge n (edge 1 = first edge with rst high)
  function automatic int pix_of(int n, int c);
    return (n <= 1) ? 0 : (n - 1) / c;
  endfunction

  // pix_en level after edge n
  function automatic bit pe_of(int n, int c);
    return (n >= 1) && ((n % c) == 0);
  endfunction

  // edge n advanced x/y
  function automatic bit adv_at(int n, int c);
    return (n >= 2) && (((n - 1) % c) == 0);
  endfunction

  function automatic cnt_t model(int i, int n);
    geo_t g;
    int   p;
    cnt_t m;
    g        = geom(i);
    p        = pix_of(n, g.c);
    m.x      = p % g.ht;
    m.y      = (p / g.ht) % g.vt;
    m.pe     = pe_of(n, g.c) ? 1 : 0;
    m.nf     = (adv_at(n, g.c) && ((p % (g.ht * g.vt)) == 0)) ? 1 : 0;
    m.active = (m.x < g.ha && m.y < g.va) ? 1 : 0;
    m.vsync  = (m.y >= g.va + g.vf && m.y < g.va + g.vf + g.vs) ? 1 : 0;
    return m;
  endfunction

  function automatic pins_t pins_for(int i, int p, logic [2:0] color);
    geo_t  g;
    int    px;
    int    py;
    pins_t r;
    g      = geom(i);
    px     = p % g.ht;
    py     = (p / g.ht) % g.vt;
    r.rgb  = (px < g.ha && py < g.va) ? color : 3'b000;
    r.hs_n = !(px >= g.ha + g.hf && px < g.ha + g.hf + g.hs);
    r.vs_n = !(py >= g.va + g.vf && py < g.va + g.vf + g.vs);
    return r;
  endfunction

  function automatic obs_t sample(int i);
    obs_t o;
    if (i == 0) begin
      o.x = int'(x_a); o.y = int'(y_a); o.vsync = int'(vsync_a); o.active = int'(active_a);
      o.pe = int'(pix_en_a); o.nf = int'(newframe_a); o.rgb = int'(vga_rgb_a);
      o.hs_n = int'(vga_hs_n_a); o.vs_n = int'(vga_vs_n_a);
    end else begin
      o.x = int'(x_b); o.y = int'(y_b); o.vsync = int'(vsync_b); o.active = int'(active_b);
      o.pe = int'(pix_en_b); o.nf = int'(newframe_b); o.rgb = int'(vga_rgb_b);
      o.hs_n = int'(vga_hs_n_b); o.vs_n = int'(vga_vs_n_b);
    end
    return o;
  endfunction

  // Model clock: counts edges since release and, on every edge that loads
  // the pins, pushes the expected pin values for the pixel being left.
  initial begin
    n_edge[0] = 0;
    n_edge[1] = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        n_edge[0] = 0;
        n_edge[1] = 0;
        q_a.delete();
        q_b.delete();
      end else begin
        if (pe_of(n_edge[0], A_C)) q_a.push_back(pins_for(0, pix_of(n_edge[0], A_C), color_a));
        if (pe_of(n_edge[1], B_C)) q_b.push_back(pins_for(1, pix_of(n_edge[1], B_C), color_b));
        n_edge[0] = n_edge[0] + 1;
        n_edge[1] = n_edge[1] + 1;
      end
    end
  end

  // Checker: pops the scoreboard when the pins load and compares every
  // output of both instances against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int    n;
        int    c;
        int    qs;
        string tag;
        cnt_t  m;
        obs_t  o;
        n   = n_edge[i];
        c   = (i == 0) ? A_C : B_C;
        tag = (i == 0) ? "a" : "b";
        if (n == 0) begin
          exp_pins[i] = '{3'b000, 1'b1, 1'b1};
        end else if (adv_at(n, c)) begin
          qs = (i == 0) ? q_a.size() : q_b.size();
          check({tag, ".sb_depth"}, qs, 1);
          if (qs > 0) begin
            if (i == 0) exp_pins[0] = q_a.pop_front();
            else        exp_pins[1] = q_b.pop_front();
          end
        end
        if (chk_en) begin
          m = model(i, n);
          o = sample(i);
          check({tag, ".x"},        o.x,      m.x);
          check({tag, ".y"},        o.y,      m.y);
          check({tag, ".vsync"},    o.vsync,  m.vsync);
          check({tag, ".active"},   o.active, m.active);
          check({tag, ".pix_en"},   o.pe,     m.pe);
          check({tag, ".newframe"}, o.nf,     m.nf);
          check({tag, ".vga_rgb"},  o.rgb,    int'(exp_pins[i].rgb));
          check({tag, ".vga_hs_n"}, o.hs_n,   int'(exp_pins[i].hs_n));
          check({tag, ".vga_vs_n"}, o.vs_n,   int'(exp_pins[i].vs_n));
        end
      end

      if (chk_en) begin
        if (int'(x_a) > max_x_a) max_x_a = int'(x_a);
        if (int'(x_b) > max_x_b) max_x_b = int'(x_b);
        if (int'(y_b) > max_y_b) max_y_b = int'(y_b);

        // newframe spacing and vsync length on the miniature raster
        if (n_edge[1] == 0) begin
          last_nf_b = 0;
          vs_cnt_b  = 0;
        end else begin
          if (newframe_b) begin
            if (last_nf_b == 0) begin
              check("b.first_newframe_edge", n_edge[1], B_C * 165 + 1);
            end else begin
              check("b.newframe_period", n_edge[1] - last_nf_b, B_C * 165);
              check("b.vsync_strobes", vs_cnt_b, B_VS * 15);
            end
            $display("b newframe at edge %0d after release", n_edge[1]);
            last_nf_b = n_edge[1];
            vs_cnt_b  = 0;
          end
          if (pix_en_b && vsync_b) vs_cnt_b++;
        end
      end

      // hsync pin width and position over line 0 of the full raster
      if (!hs_done && pe_of(n_edge[0], A_C)) begin
        int p;
        p = pix_of(n_edge[0], A_C);
        if (p >= 1 && p <= 800 && !vga_hs_n_a) begin
          hs_cnt_a++;
          if (hs_first < 0) hs_first = p;
        end
        if (p == 801) begin
          check("a.hs_low_pixels", hs_cnt_a, 96);
          check("a.hs_first_x", hs_first, 657);
          $display("a line 0 hsync: %0d pixels low starting at x=%0d", hs_cnt_a, hs_first);
          hs_done = 1'b1;
        end
      end
    end
  end

  initial begin
    // vector table: colour before edge k+1, expected outputs after it
    tbl[0] = '{3'b001, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{3'b010, 0, 1, 0, 1, 1, 2};
    tbl[2] = '{3'b110, 1, 0, 6, 2, 1, 6};
    tbl[3] = '{3'b111, 1, 1, 6, 3, 1, 7};
    tbl[4] = '{3'b101, 2, 0, 5, 4, 1, 5};
    tbl[5] = '{3'b000, 2, 1, 5, 5, 1, 0};
    tbl[6] = '{3'b011, 3, 0, 3, 6, 1, 3};
    tbl[7] = '{3'b100, 3, 1, 3, 7, 1, 4};

    // reset held for five clocks
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      obs_t  o;
      string tag;
      o   = sample(i);
      tag = (i == 0) ? "a" : "b";
      check({tag, ".rst_x"},        o.x,      0);
      check({tag, ".rst_y"},        o.y,      0);
      check({tag, ".rst_rgb"},      o.rgb,    0);
      check({tag, ".rst_hs_n"},     o.hs_n,   1);
      check({tag, ".rst_vs_n"},     o.vs_n,   1);
      check({tag, ".rst_newframe"}, o.nf,     0);
      check({tag, ".rst_pix_en"},   o.pe,     0);
      check({tag, ".rst_vsync"},    o.vsync,  0);
      check({tag, ".rst_active"},   o.active, 1);
    end
    $display("reset: a x=%0d y=%0d rgb=%0d hs_n=%0d vs_n=%0d", x_a, y_a, vga_rgb_a, vga_hs_n_a, vga_vs_n_a);

    // start-up sequence from the table
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      color_a = tbl[k].color;
      color_b = tbl[k].color;
      @(posedge clk);
      @(negedge clk);
      check("vec.a_x",       int'(x_a),       tbl[k].a_x);
      check("vec.a_pix_en",  int'(pix_en_a),  tbl[k].a_pe);
      check("vec.a_rgb",     int'(vga_rgb_a), tbl[k].a_rgb);
      check("vec.b_x",       int'(x_b),       tbl[k].b_x);
      check("vec.b_pix_en",  int'(pix_en_b),  tbl[k].b_pe);
      check("vec.b_rgb",     int'(vga_rgb_b), tbl[k].b_rgb);
      $display("vec %0d: color=%b a: x=%0d pe=%0d rgb=%b  b: x=%0d pe=%0d rgb=%b",
               k, tbl[k].color, x_a, pix_en_a, vga_rgb_a, x_b, pix_en_b, vga_rgb_b);
    end

    // free run with random colour every clock until x=300 on line 3
    chk_en = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (x_a == 10'd300 && y_a == 10'd3) break;
      color_a = 3'($urandom);
      color_b = 3'($urandom);
      @(negedge clk);
    end
    check("a.wait_x300", int'(x_a), 300);
    check("a.wait_y3",   int'(y_a), 3);

    // single-clock reset in mid-line / mid-frame
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("a.midrst_x",    int'(x_a),        0);
    check("a.midrst_y",    int'(y_a),        0);
    check("a.midrst_rgb",  int'(vga_rgb_a),  0);
    check("a.midrst_hs_n", int'(vga_hs_n_a), 1);
    check("a.midrst_vs_n", int'(vga_vs_n_a), 1);
    check("b.midrst_x",    int'(x_b),        0);
    check("b.midrst_y",    int'(y_b),        0);
    check("b.midrst_rgb",  int'(vga_rgb_b),  0);
    $display("mid-run reset: a x=%0d y=%0d  b x=%0d y=%0d", x_a, y_a, x_b, y_b);
    rst = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      color_a = 3'($urandom);
      color_b = 3'($urandom);
      @(negedge clk);
    end

    check("a.x_peak", max_x_a, 799);
    check("b.x_peak", max_x_b, 14);
    check("b.y_peak", max_y_b, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
